jesd_rx_link_ctrl: RTL and testbench



---
 rtl/jesd_pkg.sv | 24 ++
 rtl/jesd_char_classify.sv | 35 +++
 rtl/jesd_rx_link_ctrl.sv | 177 +++++++++++++++++
 tb/tb_jesd_rx_link_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jesd_pkg.sv
// Shared definitions for the JESD204B receive link controller: state encoding,
// K-character codes and a helper for recognising legal control octets.
package jesd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SYNC_REQ = 3'd1,
    ST_CGS      = 3'd2,
    ST_ILAS     = 3'd3,
    ST_DATA     = 3'd4
  } link_state_t;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K28_4 = 8'h9C;

  // Control octets that may legitimately carry a K flag inside the data phase.
  function automatic logic is_expected_k(input logic [7:0] octet);
    return (octet == K28_5) || (octet == K28_7) || (octet == K28_3);
  endfunction

endpackage

// File: rtl/jesd_char_classify.sv
// Combinational classification of one aligned octet pair into the word classes
// the link sequencer reacts to (all-K28.5, /A/ marker, /R/ marker, unexpected K).
module jesd_char_classify
  import jesd_pkg::*;
(
  input  logic [15:0] rx_data,
  input  logic [1:0]  rx_k,
  output logic        kk,
  output logic        a_hit,
  output logic        r_hit,
  output logic        bad_k
);

  logic [1:0] oct_a;
  logic [1:0] oct_r;
  logic [1:0] oct_bad;

  // rx_k[gi] qualifies octet rx_data[8*gi +: 8]
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_oct
      logic [7:0] octet;
      assign octet       = rx_data[8*gi +: 8];
      assign oct_a[gi]   = rx_k[gi] && (octet == K28_3);
      assign oct_r[gi]   = rx_k[gi] && (octet == K28_0);
      assign oct_bad[gi] = rx_k[gi] && !is_expected_k(octet);
    end
  endgenerate

  assign kk    = (rx_k == 2'b11) && (rx_data == {K28_5, K28_5});
  assign a_hit = |oct_a;
  assign r_hit = |oct_r;
  assign bad_k = |oct_bad;

endmodule

// File: rtl/jesd_rx_link_ctrl.sv
// Link-level sequencer for one 16-bit JESD204B receive lane: SYNC~ request,
// code-group sync, ILAS tracking, then DATA with loss-of-sync and K-error monitoring.
module jesd_rx_link_ctrl
  import jesd_pkg::*;
#(
  parameter int CGS_WORDS    = 4,
  parameter int SYNC_MIN     = 16,
  parameter int ILAS_MF      = 4,
  parameter int ILAS_TIMEOUT = 4096,
  parameter int LOS_KCNT     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        link_en,
  input  logic [15:0] rx_data,
  input  logic [1:0]  rx_k,
  output logic        sync_n,
  output logic        align_rearm,
  output logic        data_valid,
  output logic        ilas_done,
  output logic [2:0]  link_state,
  output logic [7:0]  err_cnt
);

  localparam int SYNC_W = $clog2(SYNC_MIN + 1);
  localparam int KK_W   = $clog2(CGS_WORDS + 1);
  localparam int TMO_W  = $clog2(ILAS_TIMEOUT + 1);
  localparam int A_W    = $clog2(ILAS_MF + 1);
  localparam int LOS_W  = $clog2(LOS_KCNT + 1);

  // Each counter transitions on the cycle its registered value is one short of the limit.
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_MIN - 1);
  localparam logic [KK_W-1:0]   CGS_LAST  = KK_W'(CGS_WORDS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ILAS_TIMEOUT - 1);
  localparam logic [A_W-1:0]    MF_LAST   = A_W'(ILAS_MF - 1);
  localparam logic [LOS_W-1:0]  LOS_LAST  = LOS_W'(LOS_KCNT - 1);

  logic kk;
  logic a_hit;
  logic r_hit;
  logic bad_k;

  jesd_char_classify u_classify (
    .rx_data (rx_data),
    .rx_k    (rx_k),
    .kk      (kk),
    .a_hit   (a_hit),
    .r_hit   (r_hit),
    .bad_k   (bad_k)
  );

  link_state_t       state_reg,        state_next;
  logic [SYNC_W-1:0] sync_cnt_reg,     sync_cnt_next;
  logic [KK_W-1:0]   kk_cnt_reg,       kk_cnt_next;
  logic [TMO_W-1:0]  tmo_cnt_reg,      tmo_cnt_next;
  logic [A_W-1:0]    a_cnt_reg,        a_cnt_next;
  logic [LOS_W-1:0]  los_cnt_reg,      los_cnt_next;
  logic              ilas_started_reg, ilas_started_next;
  logic [7:0]        err_cnt_reg,      err_cnt_next;
  logic              sync_n_reg,       sync_n_next;
  logic              rearm_reg,        rearm_next;
  logic              data_valid_reg,   data_valid_next;
  logic              ilas_done_reg,    ilas_done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      sync_cnt_reg     <= '0;
      kk_cnt_reg       <= '0;
      tmo_cnt_reg      <= '0;
      a_cnt_reg        <= '0;
      los_cnt_reg      <= '0;
      ilas_started_reg <= 1'b0;
      err_cnt_reg      <= '0;
      sync_n_reg       <= 1'b1;
      rearm_reg        <= 1'b0;
      data_valid_reg   <= 1'b0;
      ilas_done_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sync_cnt_reg     <= sync_cnt_next;
      kk_cnt_reg       <= kk_cnt_next;
      tmo_cnt_reg      <= tmo_cnt_next;
      a_cnt_reg        <= a_cnt_next;
      los_cnt_reg      <= los_cnt_next;
      ilas_started_reg <= ilas_started_next;
      err_cnt_reg      <= err_cnt_next;
      sync_n_reg       <= sync_n_next;
      rearm_reg        <= rearm_next;
      data_valid_reg   <= data_valid_next;
      ilas_done_reg    <= ilas_done_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    sync_cnt_next     = sync_cnt_reg;
    kk_cnt_next       = kk_cnt_reg;
    tmo_cnt_next      = tmo_cnt_reg;
    a_cnt_next        = a_cnt_reg;
    los_cnt_next      = los_cnt_reg;
    ilas_started_next = ilas_started_reg;
    err_cnt_next      = err_cnt_reg;
    rearm_next        = 1'b0;
    sync_n_next       = 1'b1;
    data_valid_next   = 1'b0;
    ilas_done_next    = 1'b0;

    if (!link_en) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_SYNC_REQ;
        end
        ST_SYNC_REQ: begin
          sync_cnt_next = sync_cnt_reg + 1'b1;
          if (sync_cnt_reg == SYNC_LAST) state_next = ST_CGS;
        end
        ST_CGS: begin
          kk_cnt_next = kk ? kk_cnt_reg + 1'b1 : '0;
          if (kk && (kk_cnt_reg == CGS_LAST)) state_next = ST_ILAS;
        end
        ST_ILAS: begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
          // Timeout wins over a completing /A/ count on the same word.
          if (tmo_cnt_reg == TMO_LAST) begin
            state_next = ST_SYNC_REQ;
          end else if (!ilas_started_reg) begin
            if (r_hit)   ilas_started_next = 1'b1;
            else if (!kk) state_next       = ST_SYNC_REQ;
          end else if (a_hit) begin
            a_cnt_next = a_cnt_reg + 1'b1;
            if (a_cnt_reg == MF_LAST) state_next = ST_DATA;
          end
        end
        ST_DATA: begin
          los_cnt_next = kk ? los_cnt_reg + 1'b1 : '0;
          if (kk && (los_cnt_reg == LOS_LAST)) begin
            state_next = ST_SYNC_REQ;
          end else if (bad_k && (err_cnt_reg != 8'hFF)) begin
            err_cnt_next = err_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end

    // Per-state counters restart whenever the state changes.
    if (state_next != state_reg) begin
      sync_cnt_next     = '0;
      kk_cnt_next       = '0;
      tmo_cnt_next      = '0;
      a_cnt_next        = '0;
      los_cnt_next      = '0;
      ilas_started_next = 1'b0;
      if (state_next == ST_SYNC_REQ) begin
        rearm_next   = 1'b1;
        err_cnt_next = '0;
      end
    end

    sync_n_next     = !((state_next == ST_SYNC_REQ) || (state_next == ST_CGS));
    data_valid_next = (state_next == ST_DATA);
    ilas_done_next  = (state_next == ST_DATA);
  end

  assign sync_n      = sync_n_reg;
  assign align_rearm = rearm_reg;
  assign data_valid  = data_valid_reg;
  assign ilas_done   = ilas_done_reg;
  assign link_state  = state_reg;
  assign err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_jesd_rx_link_ctrl.sv
// Self-checking bench for jesd_rx_link_ctrl: directed vector table, hand-written
// corner sequences and biased random words checked against a behavioural model.
module tb_jesd_rx_link_ctrl;

  localparam int CGS_WORDS    = 4;
  localparam int SYNC_MIN     = 16;
  localparam int ILAS_MF      = 4;
  localparam int ILAS_TIMEOUT = 4096;
  localparam int LOS_KCNT     = 4;

  localparam int P_IDLE = 0;
  localparam int P_SYNC = 1;
  localparam int P_CGS  = 2;
  localparam int P_ILAS = 3;
  localparam int P_DATA = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        link_en;
  logic [15:0] rx_data;
  logic [1:0]  rx_k;
  logic        sync_n;
  logic        align_rearm;
  logic        data_valid;
  logic        ilas_done;
  logic [2:0]  link_state;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jesd_rx_link_ctrl #(
    .CGS_WORDS    (CGS_WORDS),
    .SYNC_MIN     (SYNC_MIN),
    .ILAS_MF      (ILAS_MF),
    .ILAS_TIMEOUT (ILAS_TIMEOUT),
    .LOS_KCNT     (LOS_KCNT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .link_en     (link_en),
    .rx_data     (rx_data),
    .rx_k        (rx_k),
    .sync_n      (sync_n),
    .align_rearm (align_rearm),
    .data_valid  (data_valid),
    .ilas_done   (ilas_done),
    .link_state  (link_state),
    .err_cnt     (err_cnt)
  );

  // Behavioural model: phase plus the bookkeeping the link rules talk about.
  int m_phase;
  int m_dwell;
  int m_run;
  int m_acnt;
  int m_err;
  bit m_started;
  bit m_rearm;

  task automatic model_reset();
    m_phase = P_IDLE; m_dwell = 0; m_run = 0; m_acnt = 0;
    m_err = 0; m_started = 0; m_rearm = 0;
  endtask

  task automatic model_step(input bit le, input logic [15:0] d, input logic [1:0] k);
    bit kk, a, r, bad;
    int nxt;
    logic [7:0] o;
    kk = (k == 2'b11) && (d == 16'hBCBC);
    a = 0; r = 0; bad = 0;
    for (int i = 0; i < 2; i++) begin
      o = d[8*i +: 8];
      if (k[i]) begin
        if (o == 8'h7C) a = 1;
        if (o == 8'h1C) r = 1;
        if (o != 8'hBC && o != 8'hFC && o != 8'h7C) bad = 1;
      end
    end
    nxt = m_phase;
    if (!le) nxt = P_IDLE;
    else begin
      case (m_phase)
        P_IDLE: nxt = P_SYNC;
        P_SYNC: begin
          m_dwell++;
          if (m_dwell == SYNC_MIN) nxt = P_CGS;
        end
        P_CGS: begin
          m_run = kk ? m_run + 1 : 0;
          if (m_run == CGS_WORDS) nxt = P_ILAS;
        end
        P_ILAS: begin
          m_dwell++;
          if (m_dwell == ILAS_TIMEOUT) nxt = P_SYNC;
          else if (!m_started) begin
            if (r) m_started = 1;
            else if (!kk) nxt = P_SYNC;
          end else if (a) begin
            m_acnt++;
            if (m_acnt == ILAS_MF) nxt = P_DATA;
          end
        end
        default: begin
          m_run = kk ? m_run + 1 : 0;
          if (m_run == LOS_KCNT) nxt = P_SYNC;
          else if (bad && m_err < 255) m_err++;
        end
      endcase
    end
    m_rearm = (nxt == P_SYNC) && (m_phase != P_SYNC);
    if (nxt != m_phase) begin
      m_dwell = 0; m_run = 0; m_acnt = 0; m_started = 0;
    end
    if (m_rearm) m_err = 0;
    m_phase = nxt;
  endtask

  function automatic logic [14:0] model_vec();
    logic sn, dv;
    sn = !(m_phase == P_SYNC || m_phase == P_CGS);
    dv = (m_phase == P_DATA);
    return {sn, m_rearm, dv, dv, 3'(m_phase), 8'(m_err)};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {sync_n, align_rearm, data_valid, ilas_done, link_state, err_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic run_cycle(input bit le, input logic [15:0] d, input logic [1:0] k);
    link_en = le; rx_data = d; rx_k = k;
    @(posedge clk);
    #1;
    model_step(le, d, k);
    check("model", dut_vec(), model_vec());
  endtask

  task automatic run_until(input int phase, input int limit);
    int n;
    n = 0;
    while (m_phase != phase && n < limit) begin
      run_cycle(1'b1, 16'h0000, 2'b00);
      n++;
    end
    check("reach_state", link_state, phase);
  endtask

  task automatic bring_to_ilas();
    run_until(P_CGS, 40);
    repeat (CGS_WORDS) run_cycle(1'b1, 16'hBCBC, 2'b11);
    check("ilas_entry", link_state, P_ILAS);
  endtask

  task automatic bring_to_data();
    bring_to_ilas();
    run_cycle(1'b1, 16'h1CBC, 2'b11);
    repeat (ILAS_MF) run_cycle(1'b1, 16'h007C, 2'b01);
    check("data_entry", link_state, P_DATA);
  endtask

  task automatic pick_word(output logic [15:0] d, output logic [1:0] k);
    int p;
    p = $urandom_range(99);
    d = 16'($urandom); k = 2'b00;
    case (m_phase)
      P_CGS: if (p < 85) begin d = 16'hBCBC; k = 2'b11; end
      P_ILAS: begin
        if (!m_started) begin
          if (p < 70)      begin d = 16'hBCBC; k = 2'b11; end
          else if (p < 92) begin d = 16'h1CBC; k = 2'b11; end
          else             k = 2'($urandom);
        end else begin
          if (p < 15)      begin d = 16'h007C; k = 2'b01; end
          else if (p < 25) begin d = 16'h7C7C; k = 2'b11; end
          else if (p < 35) begin d = 16'h7C00; k = 2'b10; end
          else if (p < 80) k = 2'b00;
          else if (p < 90) begin d = 16'hBCBC; k = 2'b11; end
          else             k = 2'($urandom);
        end
      end
      P_DATA: begin
        if (p < 25)      begin d = 16'hBCBC; k = 2'b11; end
        else if (p < 40) k = 2'($urandom);
        else if (p < 45) begin d = 16'hFC00; k = 2'b10; end
      end
      default: if (p < 30) begin d = 16'hBCBC; k = 2'b11; end
    endcase
  endtask

  typedef struct {
    bit          le;
    logic [15:0] d;
    logic [1:0]  k;
    int          reps;
    logic [2:0]  st;
    bit          sn;
    bit          ra;
    bit          dv;
    logic [7:0]  err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] cgs_d [7];
    logic [1:0]  cgs_k [7];
    logic [2:0]  cgs_st[7];
    logic [15:0] rd;
    logic [1:0]  rk;
    bit          rle;

    // Nominal bring-up, data phase K errors, then loss of sync.
    tbl.push_back('{1'b1, 16'h0000, 2'b00,  1, 3'd1, 1'b0, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 16'h0000, 2'b00, 15, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 16'h0000, 2'b00,  1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 16'hBCBC, 2'b11,  3, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 16'hBCBC, 2'b11,  1, 3'd3, 1'b1, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 16'h1CBC, 2'b11,  1, 3'd3, 1'b1, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 16'h1234, 2'b00,  3, 3'd3, 1'b1, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 16'h007C, 2'b01,  3, 3'd3, 1'b1, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 16'h007C, 2'b01,  1, 3'd4, 1'b1, 1'b0, 1'b1, 8'd0});
    tbl.push_back('{1'b1, 16'hABCD, 2'b00,  2, 3'd4, 1'b1, 1'b0, 1'b1, 8'd0});
    tbl.push_back('{1'b1, 16'h11FC, 2'b01,  1, 3'd4, 1'b1, 1'b0, 1'b1, 8'd0});
    tbl.push_back('{1'b1, 16'h9C00, 2'b10,  1, 3'd4, 1'b1, 1'b0, 1'b1, 8'd1});
    tbl.push_back('{1'b1, 16'hBCBC, 2'b11,  3, 3'd4, 1'b1, 1'b0, 1'b1, 8'd1});
    tbl.push_back('{1'b1, 16'hBCBC, 2'b11,  1, 3'd1, 1'b0, 1'b1, 1'b0, 8'd0});

    model_reset();
    rst_n = 1'b0; link_en = 1'b0; rx_data = '0; rx_k = '0;
    #7;
    check("reset_state", dut_vec(), {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0});
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        run_cycle(tbl[i].le, tbl[i].d, tbl[i].k);
        check($sformatf("vec%0d", i),
              {link_state, sync_n, align_rearm, data_valid, ilas_done, err_cnt},
              {tbl[i].st, tbl[i].sn, tbl[i].ra, tbl[i].dv, tbl[i].dv, tbl[i].err});
      end
      $display("vec %0d: le=%0b d=%h k=%b x%0d -> state=%0d sync_n=%0b rearm=%0b dv=%0b err=%0d",
               i, tbl[i].le, tbl[i].d, tbl[i].k, tbl[i].reps, link_state, sync_n,
               align_rearm, data_valid, err_cnt);
    end

    // CGS interrupted by a data word: only a fresh run of four KK words completes it.
    run_until(P_CGS, 40);
    cgs_d = '{16'hBCBC, 16'hBCBC, 16'h1234, 16'hBCBC, 16'hBCBC, 16'hBCBC, 16'hBCBC};
    cgs_k = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
    cgs_st = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
    for (int i = 0; i < 7; i++) begin
      run_cycle(1'b1, cgs_d[i], cgs_k[i]);
      check($sformatf("cgs_step%0d", i), link_state, cgs_st[i]);
      $display("cgs %0d: d=%h k=%b -> state=%0d sync_n=%0b", i, cgs_d[i], cgs_k[i],
               link_state, sync_n);
    end
    check("cgs_done_sync_n", sync_n, 1'b1);

    // ILAS timeout: R marker, then data with no /A/ until the budget expires.
    run_cycle(1'b1, 16'h1CBC, 2'b11);
    repeat (ILAS_TIMEOUT - 2) run_cycle(1'b1, 16'h5555, 2'b00);
    check("ilas_before_timeout", link_state, P_ILAS);
    run_cycle(1'b1, 16'h5555, 2'b00);
    check("ilas_timeout", {link_state, sync_n, align_rearm, err_cnt},
          {3'd1, 1'b0, 1'b1, 8'd0});
    $display("ilas timeout: state=%0d sync_n=%0b rearm=%0b", link_state, sync_n, align_rearm);

    // Error counter saturation in DATA.
    bring_to_data();
    for (int i = 1; i <= 300; i++) begin
      run_cycle(1'b1, 16'h1100, 2'b10);
      if (i == 254) check("err_254", err_cnt, 8'd254);
      if (i == 255) check("err_255", err_cnt, 8'd255);
      if (i == 256) check("err_sat", err_cnt, 8'd255);
    end
    check("err_final", {err_cnt, data_valid, link_state}, {8'd255, 1'b1, 3'd4});
    $display("err sat: err_cnt=%0d data_valid=%0b", err_cnt, data_valid);

    // link_en dropped in DATA.
    run_cycle(1'b0, 16'h1234, 2'b00);
    check("link_en_off", {link_state, sync_n, align_rearm, data_valid, ilas_done},
          {3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    $display("link_en off: state=%0d sync_n=%0b", link_state, sync_n);

    // Asynchronous reset in the middle of ILAS, away from any clock edge.
    run_cycle(1'b1, 16'h0000, 2'b00);
    bring_to_ilas();
    run_cycle(1'b1, 16'h1CBC, 2'b11);
    run_cycle(1'b1, 16'h007C, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", dut_vec(), {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0});
    $display("async reset: state=%0d sync_n=%0b", link_state, sync_n);
    model_reset();
    #3 rst_n = 1'b1;
    link_en = 1'b0;
    run_cycle(1'b0, 16'h0000, 2'b00);

    // Randomised words biased by phase so every state is exercised.
    for (int n = 0; n < 3000; n++) begin
      rle = ($urandom_range(199) != 0);
      pick_word(rd, rk);
      run_cycle(rle, rd, rk);
    end
    $display("random phase done: state=%0d err_cnt=%0d", link_state, err_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
